// File: rtl/conv_result_writer.sv
// conv_result_writer
//   Write-back stage for the 3x3 convolution datapath. Each convolution
//   result arrives with a one-cycle res_valid pulse. It is divided by the
//   kernel gain (right shift by SHIFT), saturated to 8 bits and written to
//   the output block memory at BASE_ADDR + pixel index. A start pulse arms
//   one frame of NUM_PIX pixels. After the last write, frame_done is pulsed.
//
//   Build option: define CONV_WR_ROUND_EN for round-half-up normalisation.
//   When it is undefined, the result is truncated.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        one-cycle pulse, arms a frame (honoured in IDLE only)
//   res_valid    one-cycle pulse qualifying result
//   result       RES_W-bit unsigned convolution sum
//   wr_en        memory write strobe (one cycle per accepted result)
//   wr_addr      memory write address (wraps modulo 2^ADDR_W)
//   wr_data      normalised, saturated pixel
//   busy         high in ARMED and FLUSH
//   frame_done   one-cycle pulse, the cycle after the last write
//   err          sticky: res_valid seen while not armed; cleared by start
module conv_result_writer #(
  parameter int NUM_PIX   = 15876,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 15,
  parameter int RES_W     = 20,
  parameter int SHIFT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              res_valid,
  input  logic [RES_W-1:0]  result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ARMED, FLUSH, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIX - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [7:0]        pix;

  // Normalisation. In rounding mode the half-LSB is added one bit wider
  // than the result, so a full-scale input cannot wrap to a small value.
`ifdef CONV_WR_ROUND_EN
  localparam int VW = RES_W + 1;
  localparam logic [RES_W:0] HALF = (RES_W+1)'(1) << (SHIFT - 1);
  logic [VW-1:0] sum;
  logic [VW-1:0] v;
  assign sum = {1'b0, result} + HALF;
  assign v   = sum >> SHIFT;
`else
  localparam int VW = RES_W;
  logic [VW-1:0] v;
  assign v = result >> SHIFT;
`endif

  assign pix = (v > VW'(255)) ? 8'hFF : v[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARMED;
            cnt   <= '0;
            busy  <= 1'b1;
            // A result arriving in the same cycle as start is dropped and
            // still flagged, so err is set rather than cleared.
            err   <= res_valid;
          end else if (res_valid) begin
            err <= 1'b1;
          end
        end
        ARMED: begin
          // A start pulse here is ignored on purpose. The frame is neither
          // restarted nor extended.
          if (res_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= BASE + cnt;
            wr_data <= pix;
            if (cnt == LAST) state <= FLUSH;
            else             cnt   <= cnt + ADDR_W'(1);
          end
        end
        FLUSH: begin
          state      <= DONE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
          if (res_valid) err <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          if (res_valid) err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

- Write-back stage for the 3x3 convolution datapath.
- Accepts each 20-bit convolution result with its one-cycle done pulse.
- Normalises the result by the kernel gain, saturates it to 8 bits and writes it to the output block memory at sequential addresses.
- Frames the transfer: armed by a start pulse, it counts exactly one frame of pixels, then reports completion to the control FSM.

## Interface
- NUM_PIX, 15876: results (and memory writes) per frame (126x126 valid outputs); 1..2^ADDR_W.
- BASE_ADDR, 0: address of the first pixel written.
- ADDR_W, 15: write address width.
- RES_W, 20: convolution result width.
- SHIFT, 4: normalisation right shift (kernel gain 16).
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new frame.
- res_valid  in  1  one-cycle pulse; result is valid this cycle.
- result  in  RES_W  unsigned convolution sum.
- wr_en  out  1  memory write enable.
- wr_addr  out  ADDR_W  memory write address.
- wr_data  out  8  normalised, saturated pixel.
- busy  out  1  high while armed.
- frame_done  out  1  one-cycle pulse after the last write of a frame.
- err  out  1  sticky: res_valid arrived while not armed.

## Operation
- States:
  - IDLE: wait for start.
  - ARMED: accept results.
  - FLUSH: last write in flight.
  - DONE: pulse frame_done.
- Transitions:
  - IDLE, start=1 → ARMED. Pixel counter cleared to 0, err cleared.
  - ARMED, res_valid=1: write issued. If counter == NUM_PIX-1 → FLUSH; else counter+1.
  - FLUSH → DONE after one cycle.
  - DONE → IDLE after one cycle.
- Normalisation:
  - v = result >> SHIFT (RES_W-SHIFT bits).
  - wr_data = (v > 255) ? 255 : v[7:0].
- Address: wr_addr = BASE_ADDR + counter, computed modulo 2^ADDR_W (wraps silently).
- start outside IDLE is ignored; it neither restarts nor extends the frame.
- res_valid in IDLE, FLUSH or DONE:
  - no write is issued;
  - err is set and held until the next accepted start or rst.
- res_valid and start in the same IDLE cycle: start is taken, the result is dropped, err is set.
- busy is high in ARMED and FLUSH.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, err=0, state IDLE, counter 0.
- Latency: res_valid at edge N → wr_en=1 with wr_addr/wr_data valid during cycle N+1, for exactly one cycle. All outputs are registered.
- Back-to-back res_valid on every cycle is accepted at full rate, with no bubbles.
- frame_done is high in the cycle after the last wr_en (write in cycle F, frame_done in cycle F+1); busy falls in that same cycle.
- rst mid-frame: all outputs return to their reset values immediately, and any partial frame is abandoned. The first frame after reset needs a new start.
- NUM_PIX=1: the first accepted result goes directly to FLUSH.

## Configuration
- CONV_WR_ROUND_EN
  - Defined: round-half-up before the shift, v = (result + 2^(SHIFT-1)) >> SHIFT. The addition is done at RES_W+1 bits so it cannot overflow, then saturated as above.
  - Undefined: pure truncation.

## Test plan
- Reset then start; result=1600 pulsed once → next cycle wr_en=1, wr_addr=0, wr_data=100, busy=1.
- result=5000 → wr_data=255 (saturation); result=1048575 → 255; result=15 → 0.
- result=1608 → wr_data=100 without CONV_WR_ROUND_EN, 101 with it. Also result=1048575 with rounding → 255, no wrap.
- NUM_PIX=4, BASE_ADDR=100, four back-to-back res_valid:
  - writes at addresses 100..103 on consecutive cycles;
  - frame_done one cycle after the write to 103;
  - busy low from then on;
  - a fifth res_valid → no write, err=1.
- rst asserted after 2 of 4 writes → outputs 0 immediately. Subsequent res_valid writes nothing and sets err. A new start restarts at BASE_ADDR and clears err.
- start pulsed while ARMED mid-frame → counter and addresses continue unchanged; frame_done after the original NUM_PIX writes.
